// File: rtl/wb_arb_pkg.sv
// Shared defaults, entry payload and register one-hot decode for the writeback port arbiter.
package wb_arb_pkg;

    localparam int unsigned WB_DW    = 32;
    localparam int unsigned WB_AW    = 5;
    localparam int unsigned WB_DEPTH = 2;

    // Widest register address the one-hot decode supports; callers truncate the result.
    localparam int unsigned ONEHOT_AW = 8;
    localparam int unsigned ONEHOT_W  = 256;

    typedef struct packed {
        logic               valid;
        logic [WB_AW-1:0]   addr;
        logic [WB_DW-1:0]   data;
    } wb_entry_t;

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_AW-1:0] a);
        logic [ONEHOT_W-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular queue of auxiliary writeback results with per-entry valid bits,
// address-match squash and a pending-register mask.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DW    = WB_DW,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [AW-1:0]                push_addr,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    input  logic                         squash,
    input  logic [AW-1:0]                squash_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output logic [AW-1:0]                head_addr,
    output logic [DW-1:0]                head_data,
    output logic [(2**AW)-1:0]           busy_mask
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH+1);
    localparam int unsigned NREG = 2**AW;

    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;

    // Squash first, then pop/push; later assignments win on the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (squash && valid[i] && (addr_q[i] == squash_addr)) begin
                    valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= PW'(head + PW'(1));
            end
            if (push) begin
                valid[tail]  <= !(squash && (push_addr == squash_addr));
                addr_q[tail] <= push_addr;
                data_q[tail] <= push_data;
                tail         <= PW'(tail + PW'(1));
            end
            case ({push, pop})
                2'b10:   count_q <= CW'(count_q + CW'(1));
                2'b01:   count_q <= CW'(count_q - CW'(1));
                default: count_q <= count_q;
            endcase
        end
    end

    assign count      = count_q;
    assign head_valid = valid[head];
    assign head_addr  = addr_q[head];
    assign head_data  = data_q[head];

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid[i]) begin
                busy_mask = busy_mask | NREG'(onehot(ONEHOT_AW'(addr_q[i])));
            end
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority,
// queued auxiliary results drain into idle cycles. Optional macro: WB_ARB_WAW_SQUASH_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DW    = WB_DW,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pipe_wr,
    input  logic [AW-1:0]        pipe_addr,
    input  logic [DW-1:0]        pipe_data,
    input  logic                 aux_valid,
    output logic                 aux_ready,
    input  logic [AW-1:0]        aux_addr,
    input  logic [DW-1:0]        aux_data,
    output logic                 wr,
    output logic [AW-1:0]        addr3,
    output logic [DW-1:0]        data3,
    output logic [(2**AW)-1:0]   busy_mask
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic          pipe_load_c;
    logic          push_c;
    logic          pop_c;
    logic          squash_c;
    logic [CW-1:0] count;
    logic          head_valid;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    // A pipe write to $0 is treated as idle so the queue may drain.
    assign pipe_load_c = pipe_wr && (pipe_addr != '0);
    assign aux_ready   = reset && (count < CW'(DEPTH));
    assign push_c      = aux_valid && aux_ready && (aux_addr != '0);
    assign pop_c       = !pipe_load_c && (count != '0);

`ifdef WB_ARB_WAW_SQUASH_EN
    assign squash_c = pipe_load_c;
`else
    assign squash_c = 1'b0;
`endif

    wb_arb_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push        (push_c),
        .push_addr   (aux_addr),
        .push_data   (aux_data),
        .pop         (pop_c),
        .squash      (squash_c),
        .squash_addr (pipe_addr),
        .count       (count),
        .head_valid  (head_valid),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .busy_mask   (busy_mask)
    );

    // Output register; a squashed head still consumes its pop cycle as wr=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr    <= 1'b0;
            addr3 <= '0;
            data3 <= '0;
        end else if (pipe_load_c) begin
            wr    <= 1'b1;
            addr3 <= pipe_addr;
            data3 <= pipe_data;
        end else if (pop_c) begin
            wr <= head_valid;
            if (head_valid) begin
                addr3 <= head_addr;
                data3 <= head_data;
            end
        end else begin
            wr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default DW=32, AW=5, DEPTH=2).
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_wr;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;
    logic        wr;
    logic [4:0]  addr3;
    logic [31:0] data3;
    logic [31:0] busy_mask;

    int checks   = 0;
    int failures = 0;

    wb_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_wr   (pipe_wr),
        .pipe_addr (pipe_addr),
        .pipe_data (pipe_data),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_addr  (aux_addr),
        .aux_data  (aux_data),
        .wr        (wr),
        .addr3     (addr3),
        .data3     (data3),
        .busy_mask (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".wr"},    64'(wr),    64'(w));
        check({tag, ".addr3"}, 64'(addr3), 64'(a));
        check({tag, ".data3"}, 64'(data3), 64'(d));
    endtask

    initial begin
        reset     = 1'b0;
        pipe_wr   = 1'b0;
        pipe_addr = '0;
        pipe_data = '0;
        aux_valid = 1'b0;
        aux_addr  = '0;
        aux_data  = '0;

        // Reset state
        step();
        step();
        check_out("rst", 1'b0, 5'd0, 32'h0);
        check("rst.aux_ready", 64'(aux_ready), 64'(0));
        check("rst.busy",      64'(busy_mask), 64'(0));
        reset = 1'b1;
        #1;
        check("rel.aux_ready", 64'(aux_ready), 64'(1));

        // Aux path with idle pipe: two-edge latency
        aux_valid = 1'b1; aux_addr = 5'd8; aux_data = 32'h1234;
        step();
        aux_valid = 1'b0;
        check("aux.e0.busy", 64'(busy_mask), 64'h100);
        check("aux.e0.wr",   64'(wr),        64'(0));
        step();
        check_out("aux.e1", 1'b1, 5'd8, 32'h1234);
        check("aux.e1.busy", 64'(busy_mask), 64'(0));

        // Contention: pipe r1..r4 while aux r9, r10, r11
        pipe_wr = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h101;
        aux_valid = 1'b1; aux_addr = 5'd9; aux_data = 32'h909;
        check("ct1.ready", 64'(aux_ready), 64'(1));
        step();
        check_out("ct1", 1'b1, 5'd1, 32'h101);
        check("ct1.busy", 64'(busy_mask), 64'h200);
        pipe_addr = 5'd2; pipe_data = 32'h202;
        aux_addr = 5'd10; aux_data = 32'hA0A;
        check("ct2.ready", 64'(aux_ready), 64'(1));
        step();
        check_out("ct2", 1'b1, 5'd2, 32'h202);
        check("ct2.busy", 64'(busy_mask), 64'h600);
        pipe_addr = 5'd3; pipe_data = 32'h303;
        aux_addr = 5'd11; aux_data = 32'hB0B;
        check("ct3.ready", 64'(aux_ready), 64'(0));
        step();
        check_out("ct3", 1'b1, 5'd3, 32'h303);
        pipe_addr = 5'd4; pipe_data = 32'h404;
        check("ct4.ready", 64'(aux_ready), 64'(0));
        step();
        check_out("ct4", 1'b1, 5'd4, 32'h404);
        check("ct4.busy", 64'(busy_mask), 64'h600);
        pipe_wr = 1'b0;
        step();
        check_out("ct5", 1'b1, 5'd9, 32'h909);
        check("ct5.ready", 64'(aux_ready), 64'(1));
        check("ct5.busy",  64'(busy_mask), 64'h400);
        step();
        aux_valid = 1'b0;
        check_out("ct6", 1'b1, 5'd10, 32'hA0A);
        check("ct6.busy", 64'(busy_mask), 64'h800);
        step();
        check_out("ct7", 1'b1, 5'd11, 32'hB0B);
        step();
        check_out("ct8.hold", 1'b0, 5'd11, 32'hB0B);

        // $0 handling
        pipe_wr = 1'b1; pipe_addr = 5'd6; pipe_data = 32'h66;
        aux_valid = 1'b1; aux_addr = 5'd5; aux_data = 32'h55;
        step();
        check_out("z.p6", 1'b1, 5'd6, 32'h66);
        check("z.busy5", 64'(busy_mask), 64'h20);
        pipe_addr = 5'd0; pipe_data = 32'hDEAD;
        aux_valid = 1'b0;
        step();
        check_out("z.drain5", 1'b1, 5'd5, 32'h55);
        check("z.busy0", 64'(busy_mask), 64'(0));
        pipe_wr = 1'b0;
        aux_valid = 1'b1; aux_addr = 5'd0; aux_data = 32'hBAD;
        check("z.aux0.ready", 64'(aux_ready), 64'(1));
        step();
        aux_valid = 1'b0;
        check_out("z.aux0.e0", 1'b0, 5'd5, 32'h55);
        check("z.aux0.busy", 64'(busy_mask), 64'(0));
        step();
        check_out("z.aux0.e1", 1'b0, 5'd5, 32'h55);

        // WAW: queued r7 then pipe r7
        pipe_wr = 1'b1; pipe_addr = 5'd12; pipe_data = 32'hC;
        aux_valid = 1'b1; aux_addr = 5'd7; aux_data = 32'hAAAA;
        step();
        aux_valid = 1'b0;
        check_out("waw.p12", 1'b1, 5'd12, 32'hC);
        check("waw.busy7", 64'(busy_mask), 64'h80);
        pipe_addr = 5'd7; pipe_data = 32'hBBBB;
        step();
        pipe_wr = 1'b0;
        check_out("waw.pipe", 1'b1, 5'd7, 32'hBBBB);
`ifdef WB_ARB_WAW_SQUASH_EN
        check("waw.busy_sq", 64'(busy_mask), 64'(0));
        step();
        check_out("waw.drain", 1'b0, 5'd7, 32'hBBBB);
`else
        check("waw.busy_nosq", 64'(busy_mask), 64'h80);
        step();
        check_out("waw.drain", 1'b1, 5'd7, 32'hAAAA);
`endif
        check("waw.busy_end", 64'(busy_mask), 64'(0));

        // Pointer wrap: 10 push/pop pairs at full rate
        for (int i = 0; i <= 10; i++) begin
            aux_valid = (i < 10);
            aux_addr  = 5'(16 + i);
            aux_data  = 32'h1000 + 32'(i);
            if (i < 10) check("wrap.ready", 64'(aux_ready), 64'(1));
            step();
            if (i >= 1) check_out("wrap", 1'b1, 5'(16 + i - 1), 32'h1000 + 32'(i - 1));
        end
        aux_valid = 1'b0;
        step();
        check("wrap.idle.wr", 64'(wr), 64'(0));

        // Reset mid-stream with two entries queued
        pipe_wr = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h1;
        aux_valid = 1'b1; aux_addr = 5'd20; aux_data = 32'h20;
        step();
        pipe_addr = 5'd2; pipe_data = 32'h2;
        aux_addr = 5'd21; aux_data = 32'h21;
        step();
        pipe_wr = 1'b0;
        aux_valid = 1'b0;
        check("mr.busy_pre", 64'(busy_mask), 64'h300000);
        #2;
        reset = 1'b0;
        #1;
        check_out("mr.async", 1'b0, 5'd0, 32'h0);
        check("mr.busy",  64'(busy_mask), 64'(0));
        check("mr.ready", 64'(aux_ready), 64'(0));
        step();
        reset = 1'b1;
        #1;
        check("mr.rel.ready", 64'(aux_ready), 64'(1));
        step();
        check_out("mr.e0", 1'b0, 5'd0, 32'h0);
        step();
        check_out("mr.e1", 1'b0, 5'd0, 32'h0);
        check("mr.e1.busy", 64'(busy_mask), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

- Sole driver of the register file's single write port (`wr`, `addr3`, `data3`).
- Merges two result sources: the in-order pipeline writeback stream, which cannot stall, and the multi-cycle auxiliary stream (mul/div, late loads), which uses a valid/ready handshake.
- Buffers auxiliary results in a small queue and drains them into free write-port cycles.
- Exports a per-register pending mask so the hazard unit can stall readers of in-flight auxiliary results.

## Interface
Parameters:
- `DW`, 32, data width
- `AW`, 5, register address width
- `DEPTH`, 2, auxiliary queue entries (power of two, ≥2)

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pipe_wr`  in  1  pipeline writeback request (no backpressure)
- `pipe_addr`  in  AW  pipeline destination register
- `pipe_data`  in  DW  pipeline result
- `aux_valid`  in  1  auxiliary result valid
- `aux_ready`  out  1  auxiliary result accepted this cycle when high with `aux_valid`
- `aux_addr`  in  AW  auxiliary destination register
- `aux_data`  in  DW  auxiliary result
- `wr`  out  1  register file write enable (registered)
- `addr3`  out  AW  register file write address (registered)
- `data3`  out  DW  register file write data (registered)
- `busy_mask`  out  2^AW  bit r set while a valid queued auxiliary write targets r

## Operation
- **Aux accept:** the handshake completes when `aux_valid && aux_ready`.
  - `aux_ready = reset && (count < DEPTH)`.
  - `aux_ready` does not depend on a same-cycle pop.
  - An accepted write to `aux_addr == 0` is consumed and discarded; it is not enqueued.
- **Output register load (every rising edge):**
  1. `pipe_wr && pipe_addr != 0`: load the pipe write (`wr=1`). Priority is absolute.
  2. Otherwise, if the queue is non-empty: pop the head. If the head is valid, load it (`wr=1`). If it has been squashed, `wr=0`; the cycle is still consumed.
  3. Otherwise: `wr=0`. `addr3`/`data3` hold their previous values.
- A pipe write to `$0` counts as idle, so the queue may drain in that cycle.
- **Push and pop in the same edge:** both are legal. Count is unchanged and order is preserved.
- **Queue:** circular, with head/tail pointers wrapping modulo `DEPTH` and a count of 0..`DEPTH`.
  - Each entry holds {valid, addr, data}.
  - Drain order is strictly FIFO.
- **`busy_mask`:** combinational OR over valid queue entries of one-hot(addr). Bit 0 is always 0.
  - The output register is not counted: the register file commits it on the following falling edge, before the ID-stage read.
- **Starvation:** continuous pipe writes stall the drain indefinitely. The hazard unit bounds this through `busy_mask` stalls; this block adds no timeout.

## Timing
- **Reset** (asynchronous, while `reset==0`):
  - `wr=0`, `addr3=0`, `data3=0`
  - queue empty with all valid bits clear, pointers 0
  - `aux_ready=0`, `busy_mask=0`
- **Reset mid-operation:** all queued writes are discarded with no partial write. The first edge after deassertion behaves as from an empty queue.
- **Pipe latency:** request at edge N appears on `wr/addr3/data3` after edge N and is committed by the register file on the falling edge of that cycle.
- **Aux latency, idle pipe, empty queue:** accepted at edge N, output after edge N+1. Minimum 2 edges; there is no bypass path.
- **Full queue:** `aux_ready=0` until a pop edge reduces the count. Ready rises in the cycle after that pop.

## Configuration
- Macro: `WB_ARB_WAW_SQUASH_EN`.
- **Defined:** when a pipe write to r≠0 is loaded at an edge, every queued entry with addr r has its valid bit cleared at the same edge.
  - This includes an aux write to r accepted in that same edge, which is enqueued already invalid.
  - Squashed entries clear their `busy_mask` bit immediately and pop as `wr=0` cycles.
- **Undefined:** no squash. Queued entries always write in FIFO order, even after a newer pipe write to the same register. WAW safety is then solely the hazard unit's responsibility.

## Structure
- Package `wb_arb_pkg` holds:
  - `DW`/`AW`/`DEPTH` defaults
  - the `wb_entry_t` struct {valid, addr, data}
  - the one-hot decode function used by `busy_mask`
- Sub-module `wb_arb_fifo`: the circular queue with per-entry valid bits, address-match squash port, count, and `busy_mask` generation.
- The top level holds the priority mux and the output register.

## Test plan
- **Reset:** drive `reset=0` mid-stream with 2 entries queued → `wr=0`, `busy_mask=0`, `aux_ready=0`. After release, `aux_ready=1` and no stale write appears.
- **Aux path:** pipe idle, aux (r8, 0x1234) accepted at edge 0 → `busy_mask[8]=1` after edge 0. `wr=1, addr3=8, data3=0x1234` after edge 1, `busy_mask[8]=0`.
- **Contention and FIFO order:** pipe writes r1..r4 on 4 consecutive edges while aux sends r9 then r10 → third aux `aux_valid` sees `aux_ready=0`. Writes r1,r2,r3,r4 appear, then r9, then r10, in order.
- **$0 handling:** `pipe_wr` to r0 with queued r5 → r5 drains that cycle. An aux write to r0 is accepted and never appears on `wr`.
- **Squash:** with `WB_ARB_WAW_SQUASH_EN`, queued (r7, 0xAAAA) plus pipe (r7, 0xBBBB) → r7 is written with 0xBBBB only, followed by one `wr=0` drain cycle. Without the macro, 0xBBBB is written first, then 0xAAAA.
- **Pointer wrap:** perform 10 push/pop pairs at full rate → data order matches the push order across pointer wrap, and count never exceeds `DEPTH`.
